// File: rtl/input_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for board switches/keys.
// Emits a clean level and registered one-cycle rise/fall pulses per bit.
module input_debounce #(
    parameter int               WIDTH         = 14,
    parameter int               STABLE_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_event
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             any_q;
    logic             any_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A mismatch must survive STABLE_CYCLES edges; any agreement restarts it.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
            level_q <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level     = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign any_event = any_q;

endmodule
